// File: rtl/uart_pkg.sv
// Shared types and constants for the UART transmit path and its baud timer.
package uart_pkg;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    START  = 3'd1,
    DATA   = 3'd2,
    PARITY = 3'd3,
    STOP   = 3'd4
  } tx_state_t;

  localparam logic LINE_IDLE = 1'b1;
  localparam logic START_LVL = 1'b0;

  function automatic int baud_cnt_w(input int clks_per_bit);
    return (clks_per_bit <= 2) ? 1 : $clog2(clks_per_bit);
  endfunction

  function automatic int bit_cnt_w(input int data_w);
    return $clog2(data_w + 1);
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: down-counter restarted to 0 on bit entry, bit_done_o pulses on the
// last clock of each CLKS_PER_BIT period. Shared with the future receiver.
module uart_baud_tick
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = 16
) (
  input  logic clk,
  input  logic rst,
  input  logic restart_i,
  output logic bit_done_o
);

  localparam int              W      = baud_cnt_w(CLKS_PER_BIT);
  localparam logic [W-1:0]    RELOAD = W'(CLKS_PER_BIT - 1);
  localparam logic [W-1:0]    ONE    = W'(1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  // 0 marks the first clock of a bit; it reloads to CLKS_PER_BIT-1 and counts down to 1.
  always_comb begin
    cnt_d = cnt_q;
    if (restart_i) begin
      cnt_d = '0;
    end else if (cnt_q == '0) begin
      cnt_d = RELOAD;
    end else begin
      cnt_d = cnt_q - ONE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign bit_done_o = !restart_i && (cnt_q == ONE);

endmodule

// File: rtl/uart_tx_frame.sv
// Framed UART transmitter: start bit, DATA_W data bits LSB first, optional parity, stop bits.
// Build option: define UART_TX_PARITY_EN to insert the parity bit (sense from PARITY_ODD).
module uart_tx_frame
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 16,
  parameter int STOP_BITS    = 1,
  parameter int PARITY_ODD   = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              txd,
  output logic              busy
);

  localparam int               CNT_W     = bit_cnt_w(DATA_W);
  localparam logic [CNT_W-1:0] LAST_DATA = CNT_W'(DATA_W - 1);
  localparam logic [CNT_W-1:0] LAST_STOP = CNT_W'(STOP_BITS - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  tx_state_t         state_q;
  logic [DATA_W-1:0] shift_q;
  logic [CNT_W-1:0]  bit_cnt_q;
  logic              txd_q;
  logic              busy_q;
  logic              line_d;
  logic              baud_restart;
  logic              bit_done;

`ifdef UART_TX_PARITY_EN
  localparam logic ODD_SENSE = (PARITY_ODD != 0);
  logic parity_q;
`endif

  assign tx_ready     = (state_q == IDLE) && !rst;
  assign baud_restart = rst || (state_q == IDLE);

  uart_baud_tick #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_baud (
    .clk       (clk),
    .rst       (rst),
    .restart_i (baud_restart),
    .bit_done_o(bit_done)
  );

  // Line level for the current state; registered below, so txd trails state by one clock.
  always_comb begin
    line_d = LINE_IDLE;
    case (state_q)
      IDLE:    line_d = LINE_IDLE;
      START:   line_d = START_LVL;
      DATA:    line_d = shift_q[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  line_d = parity_q;
`endif
      STOP:    line_d = LINE_IDLE;
      default: line_d = LINE_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      txd_q     <= LINE_IDLE;
      busy_q    <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q  <= 1'b0;
`endif
    end else begin
      txd_q  <= line_d;
      busy_q <= (state_q != IDLE);
      case (state_q)
        IDLE: begin
          if (tx_valid) begin
            shift_q   <= tx_data;
            bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
            parity_q  <= (^tx_data) ^ ODD_SENSE;
`endif
            state_q   <= START;
          end
        end
        START: begin
          if (bit_done) state_q <= DATA;
        end
        DATA: begin
          if (bit_done) begin
            shift_q <= shift_q >> 1;
            if (bit_cnt_q == LAST_DATA) begin
              bit_cnt_q <= '0;
`ifdef UART_TX_PARITY_EN
              state_q   <= PARITY;
`else
              state_q   <= STOP;
`endif
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_ONE;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_done) state_q <= STOP;
        end
`endif
        // bit_cnt is reused to count stop bits
        STOP: begin
          if (bit_done) begin
            if (bit_cnt_q == LAST_STOP) begin
              bit_cnt_q <= '0;
              state_q   <= IDLE;
            end else begin
              bit_cnt_q <= bit_cnt_q + CNT_ONE;
            end
          end
        end
        default: begin
          state_q   <= IDLE;
          bit_cnt_q <= '0;
        end
      endcase
    end
  end

  assign txd  = txd_q;
  assign busy = busy_q;

endmodule

// File: tb/tb_uart_tx_frame.sv
// Directed bench for uart_tx_frame: table of frames plus back-to-back, reset and wide-config sequences.
module tb_uart_tx_frame;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int CPB  = 4;
  localparam int FL   = (1 + 8 + P + 1) * CPB;
  localparam int CPBW = 2;
  localparam int FLW  = (1 + 9 + P + 2) * CPBW;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] tx_data = 8'h00;
  logic       tx_valid = 1'b0;
  logic       tx_ready, txd, busy;
  logic [8:0] w_data = 9'h000;
  logic       w_valid = 1'b0;
  logic       w_ready, w_txd, w_busy;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(0)) u_dut (
    .clk(clk), .rst(rst), .tx_data(tx_data), .tx_valid(tx_valid),
    .tx_ready(tx_ready), .txd(txd), .busy(busy)
  );

  uart_tx_frame #(.DATA_W(9), .CLKS_PER_BIT(CPBW), .STOP_BITS(2), .PARITY_ODD(0)) u_wide (
    .clk(clk), .rst(rst), .tx_data(w_data), .tx_valid(w_valid),
    .tx_ready(w_ready), .txd(w_txd), .busy(w_busy)
  );

`ifdef UART_TX_PARITY_EN
  logic [7:0] o_data = 8'h00;
  logic       o_valid = 1'b0;
  logic       o_ready, o_txd, o_busy;
  uart_tx_frame #(.DATA_W(8), .CLKS_PER_BIT(CPB), .STOP_BITS(1), .PARITY_ODD(1)) u_odd (
    .clk(clk), .rst(rst), .tx_data(o_data), .tx_valid(o_valid),
    .tx_ready(o_ready), .txd(o_txd), .busy(o_busy)
  );
`endif

  typedef struct {
    logic [7:0] data;
    logic [7:0] first_to_last;
    logic       par_even;
  } vec_t;

  vec_t vecs[7];

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  // Expected line level at bit position p; ftl holds data bits in send order, MSB first.
  function automatic logic exp_bit(input logic [7:0] ftl, input logic par, input int p);
    if (p == 0) return 1'b0;
    if (p <= 8) return ftl[8 - p];
    if (P == 1 && p == 9) return par;
    return 1'b1;
  endfunction

  function automatic logic exp_wide(input logic [8:0] ftl, input int p);
    if (p == 0) return 1'b0;
    if (p <= 9) return ftl[9 - p];
    if (P == 1 && p == 10) return 1'b0;
    return 1'b1;
  endfunction

  task automatic send(input logic [7:0] d);
    int guard = 0;
    while (!tx_ready && guard < 200) begin
      @(negedge clk);
      guard++;
    end
    cmp("ready_wait", 32'(tx_ready), 32'd1);
    tx_valid = 1'b1;
    tx_data  = d;
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = ~d;
  endtask

  // Called on the negedge right after the accept edge.
  task automatic check_frame(input logic [7:0] ftl, input logic par, input int ncyc);
    cmp("lat_txd", 32'(txd), 32'd1);
    cmp("lat_busy", 32'(busy), 32'd0);
    for (int i = 0; i < ncyc; i++) begin
      @(negedge clk);
      cmp("txd", 32'(txd), 32'(exp_bit(ftl, par, i / CPB)));
      cmp("busy", 32'(busy), 32'd1);
      if (i == 0) cmp("ready_in_frame", 32'(tx_ready), 32'd0);
    end
    if (ncyc == FL) cmp("gap_ready", 32'(tx_ready), 32'd1);
  endtask

  initial begin
    logic [8:0] wide_ftl;
    wide_ftl = 9'b110101011;
    vecs[0] = '{8'hA5, 8'hA5, 1'b0};
    vecs[1] = '{8'h07, 8'hE0, 1'b1};
    vecs[2] = '{8'h3C, 8'h3C, 1'b0};
    vecs[3] = '{8'h0B, 8'hD0, 1'b1};
    vecs[4] = '{8'h96, 8'h69, 1'b0};
    vecs[5] = '{8'h00, 8'h00, 1'b0};
    vecs[6] = '{8'hFF, 8'hFF, 1'b0};

    // reset held for three edges
    @(negedge clk);
    cmp("rst_ready", 32'(tx_ready), 32'd0);
    cmp("rst_txd", 32'(txd), 32'd1);
    cmp("rst_busy", 32'(busy), 32'd0);
    cmp("rst_w_txd", 32'(w_txd), 32'd1);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    cmp("rel_ready", 32'(tx_ready), 32'd1);
    cmp("rel_txd", 32'(txd), 32'd1);
    cmp("rel_busy", 32'(busy), 32'd0);
    cmp("rel_w_ready", 32'(w_ready), 32'd1);
    @(negedge clk);

    for (int v = 0; v < 7; v++) begin
      send(vecs[v].data);
      check_frame(vecs[v].first_to_last, vecs[v].par_even, FL);
      @(negedge clk);
      cmp("tail_busy", 32'(busy), 32'd0);
      cmp("tail_txd", 32'(txd), 32'd1);
    end

    // back-to-back with tx_valid held; tx_data changes mid-frame
    tx_valid = 1'b1;
    tx_data  = 8'h01;
    @(negedge clk);
    tx_data = 8'h80;
    check_frame(8'h80, 1'b1, FL);
    @(negedge clk);
    tx_valid = 1'b0;
    tx_data  = 8'h5A;
    check_frame(8'h01, 1'b1, FL);
    @(negedge clk);
    cmp("b2b_tail_busy", 32'(busy), 32'd0);

    // reset in data bit 3 of 0xFF, with tx_valid raised alongside rst
    send(8'hFF);
    check_frame(8'hFF, 1'b0, 18);
    rst      = 1'b1;
    tx_valid = 1'b1;
    tx_data  = 8'h3C;
    @(negedge clk);
    cmp("mid_rst_txd", 32'(txd), 32'd1);
    cmp("mid_rst_busy", 32'(busy), 32'd0);
    cmp("mid_rst_ready", 32'(tx_ready), 32'd0);
    rst      = 1'b0;
    tx_valid = 1'b0;
    #1;
    cmp("post_rst_ready", 32'(tx_ready), 32'd1);
    @(negedge clk);
    cmp("no_accept_busy1", 32'(busy), 32'd0);
    @(negedge clk);
    cmp("no_accept_busy2", 32'(busy), 32'd0);
    cmp("no_accept_txd", 32'(txd), 32'd1);
    send(8'h3C);
    check_frame(8'h3C, 1'b0, FL);
    @(negedge clk);
    cmp("post_rst_tail", 32'(busy), 32'd0);

    // wide config: 9 data bits, 2 stop bits, 2 clocks per bit
    w_valid = 1'b1;
    w_data  = 9'h1AB;
    @(negedge clk);
    w_valid = 1'b0;
    w_data  = 9'h054;
    cmp("w_lat_busy", 32'(w_busy), 32'd0);
    for (int i = 0; i < FLW; i++) begin
      @(negedge clk);
      cmp("w_txd", 32'(w_txd), 32'(exp_wide(wide_ftl, i / CPBW)));
      cmp("w_busy", 32'(w_busy), 32'd1);
    end
    @(negedge clk);
    cmp("w_tail_busy", 32'(w_busy), 32'd0);
    cmp("w_tail_txd", 32'(w_txd), 32'd1);

`ifdef UART_TX_PARITY_EN
    // odd parity: 0x07 has three ones, so the parity bit is 0
    o_valid = 1'b1;
    o_data  = 8'h07;
    @(negedge clk);
    o_valid = 1'b0;
    o_data  = 8'hF8;
    for (int i = 0; i < FL; i++) begin
      @(negedge clk);
      cmp("odd_txd", 32'(o_txd), 32'(exp_bit(8'hE0, 1'b0, i / CPB)));
      cmp("odd_busy", 32'(o_busy), 32'd1);
    end
    @(negedge clk);
    cmp("odd_tail_busy", 32'(o_busy), 32'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/uart_tx_frame.md
Name: uart_tx_frame

Overview:
Parametrised UART transmitter, next generation of the team's bit-serialiser. Accepts a parallel word via valid/ready handshake and emits a framed asynchronous serial stream on txd: start bit, DATA_W data bits LSB first, optional parity, STOP_BITS stop bits. Each bit is held for CLKS_PER_BIT clocks. Sits between the host-side register/FIFO logic and the pad.

Parameters:
- DATA_W, 8, data bits per frame; legal 5..9.
- CLKS_PER_BIT, 16, clk cycles per serial bit; legal >= 2.
- STOP_BITS, 1, number of stop bits; legal 1 or 2.
- PARITY_ODD, 0, parity sense (0 = even, 1 = odd); used only when UART_TX_PARITY_EN is defined.

Ports:
- clk  input  1  system clock; all logic on rising edge.
- rst  input  1  synchronous, active-high reset.
- tx_data  input  DATA_W  word to send; sampled only on the accept cycle.
- tx_valid  input  1  tx_data is valid.
- tx_ready  output  1  block can accept a word this cycle.
- txd  output  1  serial line, idle high; registered.
- busy  output  1  frame in progress; registered.

Behaviour:
- One clock, clk. Reset is synchronous and active-high on rst (polarity and synchronicity fixed).
- Reset values: txd=1, busy=0, state=IDLE, bit/baud counters=0. tx_ready=0 while rst is high.
- tx_ready is combinational: (state==IDLE) && !rst.
- Accept occurs when tx_valid && tx_ready at a rising edge. tx_data is latched into the shift register; later changes to tx_data are ignored.
- The FSM has five states:
  - IDLE: txd=1, busy=0. Accept moves to START.
  - START: txd=0 for CLKS_PER_BIT cycles. Exits to DATA.
  - DATA: txd=shift[0]. After each CLKS_PER_BIT cycles, shift right and increment bit_cnt. After DATA_W bits, go to PARITY if enabled, otherwise STOP.
  - PARITY: txd=parity bit for CLKS_PER_BIT cycles. Exits to STOP.
  - STOP: txd=1 for STOP_BITS*CLKS_PER_BIT cycles. Exits to IDLE.
- Latency: txd falls on the edge after the accept edge, i.e. one cycle later. busy rises on the same edge as txd falls.
- busy stays 1 from that edge until the edge on which state returns to IDLE.
- Frame length is (1 + DATA_W + P + STOP_BITS) * CLKS_PER_BIT cycles, where P=1 with parity enabled, else 0.
- Back-to-back frames: at least one IDLE cycle (txd=1, tx_ready=1) separates frames. If tx_valid is held high, the next accept happens in that IDLE cycle.
- The baud counter has width $clog2(CLKS_PER_BIT). It resets to 0 on every state entry and never wraps mid-bit.
- bit_cnt has width $clog2(DATA_W+1).
- Reset mid-frame: on the next edge txd=1, busy=0, state=IDLE. The word in flight is discarded with no partial stop handling.
- tx_valid while busy: no accept, and no effect on the frame in progress.
- rst and tx_valid in the same cycle: rst wins, and nothing is accepted.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined: the PARITY state is inserted. The parity bit is the XOR of the latched data, XORed with PARITY_ODD.
- Undefined: the PARITY state and its logic are absent, frames go directly from DATA to STOP, and PARITY_ODD is ignored.

Decomposition:
- Package uart_pkg holds:
  - the state enum tx_state_t (IDLE, START, DATA, PARITY, STOP);
  - localparam helper functions for counter widths;
  - the constants LINE_IDLE=1'b1 and START_LVL=1'b0.
- One sub-module, uart_baud_tick. It is a CLKS_PER_BIT down-counter with a synchronous restart input and a one-cycle bit_done pulse, and is reusable by a future receiver.

Test Plan:
- Reset values: hold rst for 3 cycles, then release → txd=1, busy=0, tx_ready=1 on the first cycle after release.
- Basic frame: DATA_W=8, CLKS_PER_BIT=4, STOP_BITS=1, no parity; send 8'hA5 →
  - txd holds 0 for 4 cycles;
  - then 1,0,1,0,0,1,0,1, each for 4 cycles;
  - then 1 for 4 cycles;
  - busy is high for exactly 40 cycles.
- Parity frame: UART_TX_PARITY_EN defined, PARITY_ODD=0, send 8'h07 → parity bit = 1. With PARITY_ODD=1, parity bit = 0. Frame length = 44 cycles at CLKS_PER_BIT=4.
- Back-to-back: tx_valid held high with 8'h01 then 8'h80 → exactly one IDLE cycle between frames, and tx_data changes mid-frame do not corrupt the bits sent.
- Mid-frame reset: assert rst in data bit 3 of the 8'hFF frame → next cycle txd=1, busy=0. A following 8'h3C frame is correct.
- Wide config: DATA_W=9, STOP_BITS=2, CLKS_PER_BIT=2, send 9'h1AB → 9 data bits LSB first, stop high for 4 cycles, busy = 24 cycles.
